// File: rtl/noc_src_pkg.sv
// Shared types and constants for the NoC packet source.
package noc_src_pkg;

  // Frame generator FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEST,
    ST_REQH,
    ST_REQL,
    ST_WAIT
  } state_e;

  localparam int unsigned LFSR_W  = 16;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Header field layout: {src_id, dy, dx}
  localparam int unsigned COORD_W     = 4;
  localparam int unsigned HDR_DX_LSB  = 0;
  localparam int unsigned HDR_DY_LSB  = 4;
  localparam int unsigned HDR_SRC_LSB = 8;

  localparam int unsigned BEAT_W = 16;
  localparam int unsigned GAP_W  = 16;

  // One LFSR shift: feedback is the XOR of the tapped bits, shifted in at the LSB
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/noc_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//  clk  in  sampling clock
//  rst  in  synchronous reset, active-high (clears both flops)
//  d    in  asynchronous input
//  q    out synchronised output, two clk edges of latency
module noc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/noc_pkt_src.sv
// Clocked traffic source for one mesh node. Emits frames of one header flit
// plus PL payload flits over a 4-phase req/ack link to an asynchronous router.
//  clk       in   single clock
//  rst       in   synchronous reset, active-high
//  en        in   allow new frames to start
//  o_data    out  flit data, stable while o_req=1
//  o_eof     out  last payload flit marker, qualified by o_req
//  o_req     out  4-phase request
//  i_ack     in   4-phase acknowledge, asynchronous to clk
//  o_busy    out  frame in flight
//  o_frames  out  frames completed
//  o_flits   out  flits completed
module noc_pkt_src
  import noc_src_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned DIMX = 4,
  parameter int unsigned DIMY = 3,
  parameter int unsigned MYX  = 0,
  parameter int unsigned MYY  = 0,
  parameter int unsigned PL   = 8,
  parameter int unsigned GAP  = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [DW-1:0] o_data,
  output logic          o_eof,
  output logic          o_req,
  input  logic          i_ack,
  output logic          o_busy,
  output logic [31:0]   o_frames,
  output logic [31:0]   o_flits
);

  localparam int unsigned SRC_ID = MYY * DIMX + MYX;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PL - 1);

  state_e              state_q, state_n;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_n;
  logic [BEAT_W-1:0]   beat_q, beat_n, beat_inc;
  logic                hdr_q, hdr_n;
  logic [GAP_W-1:0]    gap_q, gap_n;
  logic [DW-1:0]       data_n, hdr_word;
  logic                eof_n, req_n, busy_n;
  logic [31:0]         frames_n, flits_n;
  logic [COORD_W-1:0]  dx, dy;
  logic                dest_self;
  logic                ack_s;

  // Payload beat word: {frame_no[7:0], k[7:0]} fitted to DW
  function automatic logic [DW-1:0] pay_word(input logic [7:0] fno, input logic [7:0] k);
    return DW'({fno, k});
  endfunction

  noc_sync2 u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_ack),
    .q   (ack_s)
  );

  // Destination decode from the current LFSR value and header assembly
  always_comb begin
    dx        = COORD_W'(32'(lfsr_q[7:0]) % DIMX);
    dy        = COORD_W'(32'(lfsr_q[15:8]) % DIMY);
    dest_self = (dx == COORD_W'(MYX)) && (dy == COORD_W'(MYY));
    hdr_word  = '0;
    hdr_word[HDR_DX_LSB +: COORD_W]   = dx;
    hdr_word[HDR_DY_LSB +: COORD_W]   = dy;
    hdr_word[DW-1:HDR_SRC_LSB]        = (DW - HDR_SRC_LSB)'(SRC_ID);
  end

  assign beat_inc = beat_q + BEAT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_n  = state_q;
    lfsr_n   = lfsr_q;
    beat_n   = beat_q;
    hdr_n    = hdr_q;
    gap_n    = gap_q;
    data_n   = o_data;
    eof_n    = o_eof;
    frames_n = o_frames;
    flits_n  = o_flits;

    case (state_q)
      ST_IDLE: begin
        // A high ack_s means the router is still releasing the last phase
        if (en && !ack_s) state_n = ST_DEST;
      end
      ST_DEST: begin
        lfsr_n = lfsr_step(lfsr_q);
        if (!dest_self) begin
          data_n  = hdr_word;
          eof_n   = 1'b0;
          beat_n  = '0;
          hdr_n   = 1'b1;
          state_n = ST_REQH;
        end
      end
      ST_REQH: begin
        if (ack_s) state_n = ST_REQL;
      end
      ST_REQL: begin
        if (!ack_s) begin
          flits_n = o_flits + 32'd1;
          if (hdr_q) begin
            hdr_n   = 1'b0;
            data_n  = pay_word(o_frames[7:0], 8'd0);
            eof_n   = (LAST_BEAT == '0);
            state_n = ST_REQH;
          end else if (beat_q != LAST_BEAT) begin
            beat_n  = beat_inc;
            data_n  = pay_word(o_frames[7:0], beat_inc[7:0]);
            eof_n   = (beat_inc == LAST_BEAT);
            state_n = ST_REQH;
          end else begin
            frames_n = o_frames + 32'd1;
            gap_n    = GAP_W'(GAP);
            state_n  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (gap_q == '0) state_n = ST_IDLE;
        else             gap_n   = gap_q - GAP_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    // Handshake and busy flags follow the state being entered
    req_n  = (state_n == ST_REQH);
    busy_n = (state_n == ST_DEST) || (state_n == ST_REQH) || (state_n == ST_REQL);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      beat_q   <= '0;
      hdr_q    <= 1'b0;
      gap_q    <= '0;
      o_data   <= '0;
      o_eof    <= 1'b0;
      o_req    <= 1'b0;
      o_busy   <= 1'b0;
      o_frames <= '0;
      o_flits  <= '0;
    end else begin
      state_q  <= state_n;
      lfsr_q   <= lfsr_n;
      beat_q   <= beat_n;
      hdr_q    <= hdr_n;
      gap_q    <= gap_n;
      o_data   <= data_n;
      o_eof    <= eof_n;
      o_req    <= req_n;
      o_busy   <= busy_n;
      o_frames <= frames_n;
      o_flits  <= flits_n;
    end
  end

endmodule

// File: tb/tb_noc_pkt_src.sv
// Directed bench for noc_pkt_src with a 4-phase router model and a flit scoreboard.
module tb_noc_pkt_src;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned DW   = 16;
  localparam int unsigned PL   = 2;
  localparam int unsigned GAP  = 4;
  // 0x9000 decodes to (0,0) = own node; the next value 0x2000 decodes to (0,2)
  localparam logic [15:0] SEED = 16'h9000;

  typedef struct packed {
    logic [15:0] data;
    logic        eof;
    logic        hdr;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst, en, i_ack;
  logic [DW-1:0] o_data;
  logic          o_eof, o_req, o_busy;
  logic [31:0]   o_frames, o_flits;

  int    errors = 0;
  int    checks = 0;
  int    rdly, rcnt;
  logic  rtr_on, rtr_rst;
  logic [15:0] m_lfsr;
  int    m_frame;
  flit_t sb[$];

  noc_pkt_src #(
    .DW(DW), .DIMX(4), .DIMY(3), .MYX(0), .MYY(0),
    .PL(PL), .GAP(GAP), .SEED(SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .o_data   (o_data),
    .o_eof    (o_eof),
    .o_req    (o_req),
    .i_ack    (i_ack),
    .o_busy   (o_busy),
    .o_frames (o_frames),
    .o_flits  (o_flits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference frame: skip destinations equal to (0,0), then header + PL payload beats
  task automatic push_frame();
    logic [3:0] dx, dy;
    flit_t f;
    do begin
      dx     = 4'(m_lfsr[7:0] % 8'd4);
      dy     = 4'(m_lfsr[15:8] % 8'd3);
      m_lfsr = m_step(m_lfsr);
    end while (dx == 4'd0 && dy == 4'd0);
    f.data = {8'h00, dy, dx};
    f.eof  = 1'b0;
    f.hdr  = 1'b1;
    sb.push_back(f);
    for (int k = 0; k < int'(PL); k++) begin
      f.data = {8'(m_frame), 8'(k)};
      f.eof  = (k == int'(PL) - 1);
      f.hdr  = 1'b0;
      sb.push_back(f);
    end
    m_frame++;
  endtask

  // Router model: answers each phase rdly clocks later, 1 ps after the edge
  initial begin
    flit_t e;
    i_ack = 1'b0;
    rcnt  = 0;
    forever begin
      @(posedge clk);
      #1ps;
      if (rtr_rst) begin
        i_ack = 1'b0;
        rcnt  = 0;
      end else if (rtr_on) begin
        if (o_req !== i_ack) begin
          rcnt++;
          if (rcnt >= rdly) begin
            if (o_req) begin
              if (sb.size() == 0) push_frame();
              e = sb.pop_front();
              check("flit_data", 32'(o_data), 32'(e.data));
              check("flit_eof", 32'(o_eof), 32'(e.eof));
              if (e.hdr) check("hdr_not_self", 32'(o_data[7:0] == 8'h00), 32'd0);
            end
            i_ack = o_req;
            rcnt  = 0;
          end
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  initial begin
    int n, t;
    rst = 1'b1; en = 1'b0; rtr_on = 1'b1; rtr_rst = 1'b1; rdly = 3;
    m_lfsr = SEED; m_frame = 0;
    repeat (3) @(negedge clk);
    check("rst_req",    32'(o_req),  32'd0);
    check("rst_data",   32'(o_data), 32'd0);
    check("rst_eof",    32'(o_eof),  32'd0);
    check("rst_busy",   32'(o_busy), 32'd0);
    check("rst_frames", o_frames,    32'd0);
    check("rst_flits",  o_flits,     32'd0);
    rst = 1'b0; rtr_rst = 1'b0; en = 1'b1;

    // First frame: SEED lands on own node, so DEST lasts two cycles
    n = 0; t = 0;
    while (!o_req && t < 50) begin
      @(negedge clk);
      if (o_busy && !o_req) n++;
      t++;
    end
    check("first_req_seen", 32'(o_req), 32'd1);
    check("dest_cycles", 32'(n), 32'd2);
    check("first_hdr", 32'(o_data), 32'h0020);
    t = 0;
    while (o_frames != 32'd1 && t < 300) begin @(negedge clk); t++; end
    check("frame1_frames", o_frames, 32'd1);
    check("frame1_flits",  o_flits,  32'd3);
    // Idle span: GAP countdown plus the IDLE decision cycle
    n = 0; t = 0;
    while (!o_busy && t < 50) begin n++; @(negedge clk); t++; end
    check("gap_cycles", 32'(n >= int'(GAP) && n <= int'(GAP) + 2), 32'd1);

    // Drop en at the second payload: frame still completes, then park
    t = 0;
    while (!(o_req && o_eof) && t < 300) begin @(negedge clk); t++; end
    check("second_payload_seen", 32'(o_req && o_eof), 32'd1);
    en = 1'b0;
    t = 0;
    while (o_busy && t < 300) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    check("endrop_frames", o_frames, 32'd2);
    check("endrop_flits",  o_flits,  32'd6);
    check("endrop_busy",   32'(o_busy), 32'd0);
    check("endrop_req",    32'(o_req),  32'd0);
    check("endrop_sb_empty", 32'(sb.size()), 32'd0);

    // Router still high in IDLE: no frame may start until ack_s falls
    rtr_on = 1'b0;
    i_ack  = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    check("ackhold_req",  32'(o_req),  32'd0);
    check("ackhold_busy", 32'(o_busy), 32'd0);
    i_ack = 1'b0;
    t = 0;
    while (!o_busy && t < 10) begin @(negedge clk); t++; end
    check("ackrel_busy", 32'(o_busy), 32'd1);
    check("ackrel_latency", 32'(t >= 2), 32'd1);
    rtr_on = 1'b1;
    t = 0;
    while (o_frames != 32'd3 && t < 300) begin @(negedge clk); t++; end
    check("frame3_frames", o_frames, 32'd3);

    // Reset together with the router while in REQH
    t = 0;
    while (!o_req && t < 300) begin @(negedge clk); t++; end
    check("reqh_seen", 32'(o_req), 32'd1);
    rst = 1'b1; rtr_rst = 1'b1;
    @(negedge clk);
    check("midrst_req",    32'(o_req),  32'd0);
    check("midrst_data",   32'(o_data), 32'd0);
    check("midrst_busy",   32'(o_busy), 32'd0);
    check("midrst_frames", o_frames,    32'd0);
    check("midrst_flits",  o_flits,     32'd0);
    sb.delete();
    m_lfsr = SEED; m_frame = 0; rdly = 1;
    @(negedge clk);
    rst = 1'b0; rtr_rst = 1'b0;
    t = 0;
    while (!o_req && t < 50) begin @(negedge clk); t++; end
    check("postrst_hdr", 32'(o_data), 32'h0020);

    // Long run with acks changing 1 ps after edges
    t = 0;
    while (o_frames < 32'd1000 && t < 60000) begin @(negedge clk); t++; end
    en = 1'b0;
    check("long_done", 32'(o_frames >= 32'd1000), 32'd1);
    repeat (20) @(negedge clk);
    check("long_frames", o_frames, 32'd1000);
    check("long_flits",  o_flits,  32'(1000 * (PL + 1)));
    check("long_busy",   32'(o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
